// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes,
// per-phase lamp vectors and default timing.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_G1   = 3'd1,
    ST_Y1   = 3'd2,
    ST_AR1  = 3'd3,
    ST_G2   = 3'd4,
    ST_Y2   = 3'd5,
    ST_AR2  = 3'd6
  } phase_t;

  // Lamp vectors are packed as {GRN1, YLW1, RED1, GRN2, YLW2, RED2}.
  localparam logic [5:0] LAMP_ALLRED = 6'b001_001;
  localparam logic [5:0] LAMP_G1     = 6'b100_001;
  localparam logic [5:0] LAMP_Y1     = 6'b010_001;
  localparam logic [5:0] LAMP_G2     = 6'b001_100;
  localparam logic [5:0] LAMP_Y2     = 6'b001_010;

  localparam int DEF_PRESCALE = 16;
  localparam int DEF_MIN_GRN  = 6;
  localparam int DEF_MAX_GRN  = 12;
  localparam int DEF_YLW_T    = 3;
  localparam int DEF_AR_T     = 1;
  localparam int DEF_TW       = 4;

  function automatic logic [5:0] lamp_of(input phase_t p);
    logic [5:0] l;
    case (p)
      ST_G1:   l = LAMP_G1;
      ST_Y1:   l = LAMP_Y1;
      ST_G2:   l = LAMP_G2;
      ST_Y2:   l = LAMP_Y2;
      ST_INIT: l = LAMP_ALLRED;
      ST_AR1:  l = LAMP_ALLRED;
      ST_AR2:  l = LAMP_ALLRED;
      default: l = LAMP_ALLRED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Dwell-tick prescaler: one-cycle registered strobe every PRESCALE clocks,
// or every clock while TEST is high.
module traffic_tick_gen #(
  parameter int PRESCALE = 16
) (
  input  logic CK,
  input  logic CLR,
  input  logic TEST,
  output logic TICK
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_r;
  logic          tick_r;

  // Prescale counter and tick strobe; test mode parks the counter at zero.
  always_ff @(posedge CK) begin
    if (!CLR) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (TEST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + PW'(1);
      tick_r <= 1'b0;
    end
  end

  assign TICK = tick_r;

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase scheduler: phase FSM, dwell timer, vehicle
// request latches, preemption arbitration and registered lamp drive.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int MIN_GRN  = DEF_MIN_GRN,
  parameter int MAX_GRN  = DEF_MAX_GRN,
  parameter int YLW_T    = DEF_YLW_T,
  parameter int AR_T     = DEF_AR_T,
  parameter int TW       = DEF_TW
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       TEST,
  input  logic       MR,
  input  logic       FM,
  input  logic       PRE1,
  input  logic       PRE2,
  output logic       GRN1,
  output logic       YLW1,
  output logic       RED1,
  output logic       GRN2,
  output logic       YLW2,
  output logic       RED2,
  output logic [2:0] PHASE,
  output logic       TICK
);

  localparam logic [TW:0]   MIN_N = (TW+1)'(MIN_GRN);
  localparam logic [TW:0]   MAX_N = (TW+1)'(MAX_GRN);
  localparam logic [TW:0]   YLW_N = (TW+1)'(YLW_T);
  localparam logic [TW:0]   AR_N  = (TW+1)'(AR_T);
  localparam logic [TW-1:0] TMAX  = '1;

  phase_t        state_r;
  phase_t        state_nxt_s;
  logic [TW-1:0] timer_r;
  logic          req1_r;
  logic          req2_r;
  logic [5:0]    lamp_r;
  logic          tick_s;
  logic          g1_exit_s;
  logic          g2_exit_s;
  logic          enter_g1_s;
  logic          enter_g2_s;

  // The transition fires on the tick that completes the Nth dwell interval.
  function automatic logic reach(input logic [TW-1:0] t, input logic [TW:0] n);
    return ({1'b0, t} + (TW+1)'(1)) >= n;
  endfunction

  traffic_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .CK   (CK),
    .CLR  (CLR),
    .TEST (TEST),
    .TICK (tick_s)
  );

  // Green-exit conditions; a held PRE1 pins road 1 green and PRE1 beats PRE2.
  always_comb begin
    g1_exit_s = 1'b0;
    g2_exit_s = 1'b0;
    g1_exit_s = (PRE2 & ~PRE1)
              | (~PRE1 & req2_r & ((reach(timer_r, MIN_N) & ~MR) | reach(timer_r, MAX_N)));
    g2_exit_s = PRE1
              | (~PRE2 & ((reach(timer_r, MIN_N) & ~FM) | (req1_r & reach(timer_r, MAX_N))));
  end

  // Next-phase decode; every move is qualified by the dwell tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: if (tick_s && reach(timer_r, AR_N))  state_nxt_s = ST_G1;
               else                                 state_nxt_s = ST_INIT;
      ST_G1:   if (tick_s && g1_exit_s)             state_nxt_s = ST_Y1;
               else                                 state_nxt_s = ST_G1;
      ST_Y1:   if (tick_s && reach(timer_r, YLW_N)) state_nxt_s = ST_AR1;
               else                                 state_nxt_s = ST_Y1;
      ST_AR1:  if (tick_s && reach(timer_r, AR_N))  state_nxt_s = ST_G2;
               else                                 state_nxt_s = ST_AR1;
      ST_G2:   if (tick_s && g2_exit_s)             state_nxt_s = ST_Y2;
               else                                 state_nxt_s = ST_G2;
      ST_Y2:   if (tick_s && reach(timer_r, YLW_N)) state_nxt_s = ST_AR2;
               else                                 state_nxt_s = ST_Y2;
      ST_AR2:  if (tick_s && reach(timer_r, AR_N))  state_nxt_s = ST_G1;
               else                                 state_nxt_s = ST_AR2;
      default:                                      state_nxt_s = ST_INIT;
    endcase
  end

  // Green-entry strobes used to retire the matching request latch.
  always_comb begin
    enter_g1_s = 1'b0;
    enter_g2_s = 1'b0;
    enter_g1_s = (state_nxt_s == ST_G1) && (state_r != ST_G1);
    enter_g2_s = (state_nxt_s == ST_G2) && (state_r != ST_G2);
  end

  // Phase register, dwell timer, request latches and lamp drive.
  always_ff @(posedge CK) begin
    if (!CLR) begin
      state_r <= ST_INIT;
      timer_r <= '0;
      req1_r  <= 1'b0;
      req2_r  <= 1'b0;
      lamp_r  <= LAMP_ALLRED;
    end else begin
      state_r <= state_nxt_s;
      lamp_r  <= lamp_of(state_nxt_s);

      if (state_nxt_s != state_r) begin
        timer_r <= '0;
      end else if (tick_s && (timer_r != TMAX)) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= timer_r;
      end

      // A sensor hit in the entry cycle keeps the request alive.
      if (MR) begin
        req1_r <= 1'b1;
      end else if (enter_g1_s) begin
        req1_r <= 1'b0;
      end else begin
        req1_r <= req1_r;
      end

      if (FM) begin
        req2_r <= 1'b1;
      end else if (enter_g2_s) begin
        req2_r <= 1'b0;
      end else begin
        req2_r <= req2_r;
      end
    end
  end

  assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = lamp_r;
  assign PHASE = state_r;
  assign TICK  = tick_s;

endmodule
